// File: rtl/rca_resp_checker.sv
// rca_resp_checker: response analyser for a WIDTH-bit ripple-carry adder with a 2-stage capture/compare pipeline.
// Optional build macro RCA_CHK_MISR_EN adds a 16-bit MISR over DUT results; otherwise signature is tied to zero.

module rca_resp_checker #(
   parameter int WIDTH       = 4,
   parameter int NUM_VECTORS = 256,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_cin,
   input  logic [WIDTH-1:0]     dut_sum,
   input  logic                 dut_cout,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 mismatch,
   output logic [CNT_W-1:0]     vec_cnt,
   output logic [CNT_W-1:0]     err_cnt,
   output logic                 first_err_valid,
   output logic [2*WIDTH:0]     first_err_vec,
   output logic [15:0]          signature
);

   // state | meaning
   // IDLE  | waiting for start
   // RUN   | capturing and checking vectors
   // DONE  | NUM_VECTORS checked, results held until start

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_e;

   localparam logic [CNT_W-1:0] NUM_V = CNT_W'(NUM_VECTORS);

   state_e             state_q, state_d;
   logic               s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_sum_q, s1_sum_d;
   logic               s1_cin_q, s1_cin_d, s1_cout_q, s1_cout_d;
   logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d, err_cnt_q, err_cnt_d;
   logic               mismatch_q, mismatch_d, pass_q, pass_d;
   logic               fe_valid_q, fe_valid_d;
   logic [2*WIDTH:0]   fe_vec_q, fe_vec_d;
   logic [WIDTH:0]     exp_res;
   logic               cap, chk, bad;

   assign exp_res = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_cin_q};
   assign cap     = (state_q == ST_RUN) && in_valid && !start;
   // vectors beyond NUM_VECTORS fall out of the pipeline unchecked
   assign chk     = s1_valid_q && (vec_cnt_q < NUM_V);
   assign bad     = chk && (exp_res != {s1_cout_q, s1_sum_q});

   always_comb begin
      state_d    = state_q;
      s1_valid_d = cap;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_cin_d   = s1_cin_q;
      s1_sum_d   = s1_sum_q;
      s1_cout_d  = s1_cout_q;
      vec_cnt_d  = vec_cnt_q;
      err_cnt_d  = err_cnt_q;
      mismatch_d = bad;
      pass_d     = pass_q;
      fe_valid_d = fe_valid_q;
      fe_vec_d   = fe_vec_q;

      if (cap) begin
         s1_a_d    = in_a;
         s1_b_d    = in_b;
         s1_cin_d  = in_cin;
         s1_sum_d  = dut_sum;
         s1_cout_d = dut_cout;
      end

      if (chk) begin
         vec_cnt_d = vec_cnt_q + 1'b1;
         if (bad && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
         if (bad && !fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_vec_d   = {s1_a_q, s1_b_q, s1_cin_q};
         end
      end

      case (state_q)
         ST_RUN: begin
            if (chk && (vec_cnt_d == NUM_V)) begin
               state_d = ST_DONE;
               pass_d  = (err_cnt_d == '0);
            end
         end
         default: ;
      endcase

      if (start) begin
         state_d    = ST_RUN;
         s1_valid_d = 1'b0;
         vec_cnt_d  = '0;
         err_cnt_d  = '0;
         mismatch_d = 1'b0;
         pass_d     = 1'b0;
         fe_valid_d = 1'b0;
         fe_vec_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_cin_q   <= 1'b0;
         s1_sum_q   <= '0;
         s1_cout_q  <= 1'b0;
         vec_cnt_q  <= '0;
         err_cnt_q  <= '0;
         mismatch_q <= 1'b0;
         pass_q     <= 1'b0;
         fe_valid_q <= 1'b0;
         fe_vec_q   <= '0;
      end else begin
         state_q    <= state_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_cin_q   <= s1_cin_d;
         s1_sum_q   <= s1_sum_d;
         s1_cout_q  <= s1_cout_d;
         vec_cnt_q  <= vec_cnt_d;
         err_cnt_q  <= err_cnt_d;
         mismatch_q <= mismatch_d;
         pass_q     <= pass_d;
         fe_valid_q <= fe_valid_d;
         fe_vec_q   <= fe_vec_d;
      end
   end

`ifdef RCA_CHK_MISR_EN
   logic [15:0] sig_q, sig_d;

   // Galois MISR, x^16+x^12+x^3+x+1: shift first, then fold in the result
   always_comb begin
      sig_d = sig_q;
      if (start) begin
         sig_d = 16'hFFFF;
      end else if (chk) begin
         sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h100B : 16'h0000);
         sig_d = sig_d ^ 16'({s1_cout_q, s1_sum_q});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_q <= 16'h0000;
      else        sig_q <= sig_d;
   end

   assign signature = sig_q;
`else
   assign signature = 16'h0000;
`endif

   assign busy            = (state_q == ST_RUN);
   assign done            = (state_q == ST_DONE);
   assign pass            = pass_q;
   assign mismatch        = mismatch_q;
   assign vec_cnt         = vec_cnt_q;
   assign err_cnt         = err_cnt_q;
   assign first_err_valid = fe_valid_q;
   assign first_err_vec   = fe_vec_q;

endmodule

// File: tb/tb_rca_resp_checker.sv
// tb_rca_resp_checker: directed bench for rca_resp_checker with hand-computed expectations.
// Signature checks follow RCA_CHK_MISR_EN (model when defined, zero otherwise).

module tb_rca_resp_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  in_a = '0, in_b = '0, dut_sum = '0;
   logic        in_cin = 1'b0, dut_cout = 1'b0;
   logic        busy, done, pass, mismatch, first_err_valid;
   logic [15:0] vec_cnt, err_cnt, signature;
   logic [8:0]  first_err_vec;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          mm_cnt = 0;
   logic [15:0] sig_exp = 16'h0000;
   logic [15:0] sig1 = 16'h0000;

   rca_resp_checker #(.WIDTH(4), .NUM_VECTORS(256), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .dut_sum(dut_sum), .dut_cout(dut_cout),
      .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
      .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_valid(first_err_valid),
      .first_err_vec(first_err_vec), .signature(signature)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [4:0] r);
      logic [15:0] n;
      n = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000);
      return n ^ {11'b0, r};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (mismatch) mm_cnt++;
   endtask

   task automatic drive_vec(input logic [3:0] a, input logic [3:0] b, input logic c,
                            input bit force_b0, input bit flip_cout);
      logic [4:0] res;
      res = {1'b0, a} + {1'b0, b} + {4'b0, c};
      if (force_b0) res[0] = 1'b1;
      if (flip_cout) res[4] = ~res[4];
      in_a = a; in_b = b; in_cin = c;
      {dut_cout, dut_sum} = res;
      in_valid = 1'b1;
      sig_exp = misr_step(sig_exp, res);
   endtask

   task automatic do_start();
      start = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      sig_exp = 16'hFFFF;
      mm_cnt = 0;
   endtask

   task automatic sweep(input int n, input bit force_b0, input int bad_idx);
      logic [7:0] v;
      do_start();
      check("start_done", done, 0);
      check("start_pass", pass, 0);
      check("start_vec", vec_cnt, 0);
      check("start_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         v = 8'(i);
         drive_vec(v[7:4], v[3:0], 1'b0, force_b0, i == bad_idx);
         tick();
         if (i == 128) check("pass_low_in_run", pass, 0);
      end
      in_valid = 1'b0;
   endtask

   task automatic check_sig(input string tag);
`ifdef RCA_CHK_MISR_EN
      check(tag, signature, sig_exp);
`else
      check(tag, signature, 16'h0000);
`endif
   endtask

   initial begin
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_vec", vec_cnt, 0);
      check("rst_sig", signature, 0);
      rst_n = 1'b1;
      tick();

      // full correct sweep
      sweep(256, 1'b0, -1);
      check("last_edge_done", done, 0);
      check("last_edge_busy", busy, 1);
      tick();
      check("s1_done", done, 1);
      check("s1_pass", pass, 1);
      check("s1_busy", busy, 0);
      check("s1_vec", vec_cnt, 256);
      check("s1_err", err_cnt, 0);
      check("s1_fev", first_err_valid, 0);
      check("s1_mm", mm_cnt, 0);
      check_sig("s1_sig");
`ifdef RCA_CHK_MISR_EN
      check("s1_sig_nz", signature != 16'h0000, 1);
`endif
      sig1 = signature;

      // in_valid in DONE is ignored
      for (int i = 0; i < 3; i++) begin
         drive_vec(4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      check("done_ign_vec", vec_cnt, 256);
      check("done_ign_err", err_cnt, 0);
      check("done_hold", done, 1);

      // sum bit0 stuck at 1
      sweep(256, 1'b1, -1);
      tick();
      check("s2_done", done, 1);
      check("s2_pass", pass, 0);
      check("s2_err", err_cnt, 128);
      check("s2_mm", mm_cnt, 128);
      check("s2_fev", first_err_valid, 1);
      check("s2_fevec", first_err_vec, 9'h000);

      // repeat correct sweep: signature reproduces
      sweep(256, 1'b0, -1);
      tick();
      check("s6_pass", pass, 1);
      check_sig("s6_sig_rep");
`ifdef RCA_CHK_MISR_EN
      check("s6_sig_same", signature, sig1);
`endif

      // single corrupted result (a=2,b=5 cout flipped)
      sweep(256, 1'b0, 37);
      tick();
      check("s6_err1", err_cnt, 1);
      check("s6_mm1", mm_cnt, 1);
      check("s6_fevec", first_err_vec, 9'h04A);
      check_sig("s6_sig_bad");
`ifdef RCA_CHK_MISR_EN
      check("s6_sig_diff", signature != sig1, 1);
`endif

      // single-vector latency
      do_start();
      drive_vec(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
      tick();
      drive_vec(4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
      tick();
      check("s3_good_mm", mismatch, 0);
      in_valid = 1'b0;
      tick();
      check("s3_bad_mm", mismatch, 1);
      tick();
      check("s3_mm_pulse", mismatch, 0);
      check("s3_vec", vec_cnt, 2);
      check("s3_err", err_cnt, 1);
      check("s3_fevec", first_err_vec, 9'h1FF);

      // start with in_valid drops the vector and flushes the pipeline
      drive_vec(4'h1, 4'h2, 1'b0, 1'b0, 1'b1);
      tick();
      drive_vec(4'h3, 4'h3, 1'b0, 1'b0, 1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      sig_exp = 16'hFFFF;
      mm_cnt = 0;
      check("s5_vec0", vec_cnt, 0);
      tick();
      tick();
      check("s5_vec_flush", vec_cnt, 0);
      check("s5_err_flush", err_cnt, 0);
      check("s5_mm", mm_cnt, 0);
      check("s5_fev", first_err_valid, 0);
      check_sig("s5_sig_seed");

      // reset mid-run
      sweep(100, 1'b1, -1);
      check("s4_pre_err", err_cnt, 50);
      #3 rst_n = 1'b0;
      #1;
      check("s4_rst_vec", vec_cnt, 0);
      check("s4_rst_err", err_cnt, 0);
      check("s4_rst_busy", busy, 0);
      check("s4_rst_fev", first_err_valid, 0);
      check("s4_rst_sig", signature, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_vec(4'h5, 4'h6, 1'b0, 1'b0, 1'b1);
         tick();
      end
      in_valid = 1'b0;
      check("idle_ign_vec", vec_cnt, 0);
      check("idle_busy", busy, 0);
      sweep(256, 1'b0, -1);
      tick();
      check("s4_done", done, 1);
      check("s4_vec", vec_cnt, 256);
      check("s4_err", err_cnt, 0);
      check("s4_pass", pass, 1);
      check_sig("s4_sig");

      // start in DONE clears done and pass next cycle
      do_start();
      check("s5_done_clr", done, 0);
      check("s5_pass_clr", pass, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
